hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 4, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (1..15).
REQ-003 SHALL have parameter MD_LAT, default 4, multiply/divide busy cycles (1..15).
REQ-004 SHALL have parameter R0_ZERO, default 1; when 1, address 0 never matches.
REQ-005 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-006 Ports: clk  in  1  rising-edge clock; one clock, no other clock domain.
REQ-007 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-008 Ports: id_rs1, id_rs2  in  REG_AW  ID-stage source addresses; id_rs1_used, id_rs2_used  in  1  source-valid flags.
REQ-009 Ports: ex_rd  in  REG_AW  EX-stage destination; ex_mem_read  in  1  EX instruction is a load.
REQ-010 Ports: id_md_start  in  1  ID holds mul/div; id_halt  in  1  ID holds HALT; resume  in  1  leave halt; ex_branch_taken  in  1  redirect.
REQ-011 Ports: pc_write, ifid_write  out  1  enables (1 = advance); idex_bubble  out  1  insert NOP into ID/EX; ifid_flush  out  1  kill IF/ID.
REQ-012 Ports: halted  out  1; md_busy  out  1; stall_cycles  out  CNT_W  saturating stall count.

Function
REQ-013 States SHALL be RUN, LOAD_STALL, MD_BUSY, HALTED, plus a 4-bit down-counter cnt.
REQ-014 load_hit SHALL be ex_mem_read & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)), forced 0 when R0_ZERO=1 and ex_rd==0.
REQ-015 Stall outputs (pc_write=0, ifid_write=0, idex_bubble=1) SHALL be combinational from state and inputs, asserted in the detection cycle; no extra latency.
REQ-016 RUN priority SHALL be: ex_branch_taken > load_hit > id_md_start > id_halt.
REQ-017 RUN, ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1; stay RUN; lower-priority events ignored that cycle.
REQ-018 RUN, load_hit: stall this cycle; if LOAD_LAT>1 go LOAD_STALL with cnt=LOAD_LAT-1, else stay RUN.
REQ-019 LOAD_STALL: stall every cycle, decrement cnt; go RUN on the cycle cnt reaches 1; ex_branch_taken aborts to RUN with flush (stall not asserted).
REQ-020 RUN, id_md_start: no stall this cycle (instruction issues); go MD_BUSY with cnt=MD_LAT.
REQ-021 MD_BUSY: md_busy=1, stall every cycle, decrement cnt; go RUN on the cycle cnt reaches 1; ex_branch_taken drives ifid_flush but does not abort.
REQ-022 RUN, id_halt: stall this cycle, go HALTED.
REQ-023 HALTED: halted=1, pc_write=0, ifid_write=0, idex_bubble=1; ex_branch_taken ignored; resume=1 returns to RUN next cycle.
REQ-024 ifid_flush SHALL be 0 in HALTED and otherwise equal ex_branch_taken.
REQ-025 stall_cycles SHALL increment by 1 on each clock where pc_write=0, saturating at all-ones.
REQ-026 Outside the listed cases, outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state RUN, cnt=0, stall_cycles=0, including mid-stall or halted.
REQ-028 While in reset outputs SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, halted=0, md_busy=0.

Structure
REQ-029 State enum and default latency constants SHALL live in shared package cpu_pkg.
REQ-030 Address compare SHALL be one sub-module, hazard_cmp (REG_AW parameter), instantiated once per source operand.

Verification
REQ-031 ex_mem_read=1, ex_rd=3, id_rs2=3, id_rs2_used=1, LOAD_LAT=2 -> stall 2 cycles, stall_cycles=2, then pc_write=1.
REQ-032 Same with ex_rd=0, R0_ZERO=1 -> no stall; R0_ZERO=0 -> 1-cycle stall.
REQ-033 id_md_start pulse, MD_LAT=4 -> issue cycle unstalled, then md_busy=1 and stall exactly 4 cycles.
REQ-034 ex_branch_taken=1 with load_hit=1 and id_halt=1 same cycle -> ifid_flush=1, idex_bubble=1, no stall, stays RUN.
REQ-035 id_halt -> halted=1 and pc_write=0 held 10 cycles, stall_cycles=11; resume pulse -> RUN next cycle.
REQ-036 rst_n low mid-MD_BUSY (cnt=2) -> immediately md_busy=0, pc_write=1, stall_cycles=0; CNT_W=4 run of 20 stalls -> saturates at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared hazard-controller state encoding and default latencies.
package cpu_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_LOAD_STALL, ST_MD_BUSY, ST_HALTED} state_e;
    localparam int LOAD_LAT_DEF = 1;
    localparam int MD_LAT_DEF = 4;
    localparam int CNT_W_DEF = 16;
    localparam int LAT_W = 4;
endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: flags a source operand that reads the EX-stage destination.
module hazard_cmp #(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic              used_i,
    output logic              hit_o
);
    assign hit_o = used_i && (src_i == dst_i);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use, mul/div busy, halt and branch-flush pipeline control.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int MD_LAT   = MD_LAT_DEF,
    parameter int R0_ZERO  = 1,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              id_md_start,
    input  logic              id_halt,
    input  logic              resume,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              halted,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cycles
);
    state_e state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic hit1, hit2, load_hit, stall, flush, bubble;

    hazard_cmp #(.REG_AW(REG_AW)) u_cmp1 (.src_i(id_rs1), .dst_i(ex_rd), .used_i(id_rs1_used), .hit_o(hit1));
    hazard_cmp #(.REG_AW(REG_AW)) u_cmp2 (.src_i(id_rs2), .dst_i(ex_rd), .used_i(id_rs2_used), .hit_o(hit2));

    assign load_hit = ex_mem_read && (hit1 || hit2) && !(R0_ZERO != 0 && ex_rd == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush  = 1'b1;
                    bubble = 1'b1;
                end else if (load_hit) begin
                    stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = ST_LOAD_STALL;
                        cnt_d   = LAT_W'(LOAD_LAT - 1);
                    end
                end else if (id_md_start) begin
                    state_d = ST_MD_BUSY;
                    cnt_d   = LAT_W'(MD_LAT);
                end else if (id_halt) begin
                    stall   = 1'b1;
                    state_d = ST_HALTED;
                end
            end
            ST_LOAD_STALL: begin
                if (ex_branch_taken) begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    stall   = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == 1) ? ST_RUN : ST_LOAD_STALL;
                end
            end
            ST_MD_BUSY: begin
                // the multi-cycle unit keeps running across a redirect
                stall   = 1'b1;
                flush   = ex_branch_taken;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == 1) ? ST_RUN : ST_MD_BUSY;
            end
            default: begin
                stall   = 1'b1;
                state_d = resume ? ST_RUN : ST_HALTED;
            end
        endcase
    end

    // outputs are gated by rst_n so reset overrides any live hazard inputs
    assign pc_write     = !(rst_n && stall);
    assign ifid_write   = pc_write;
    assign idex_bubble  = rst_n && (stall || bubble);
    assign ifid_flush   = rst_n && flush;
    assign halted       = rst_n && (state_q == ST_HALTED);
    assign md_busy      = rst_n && (state_q == ST_MD_BUSY);
    assign stall_cycles = stall_q;
    assign stall_d      = (!pc_write && stall_q != {CNT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: two parameterisations driven in lockstep, scoreboarded against a cycle-count model.
module tb_hazard_stall_ctrl;
    typedef struct packed {
        logic        pc;
        logic        ifid;
        logic        bub;
        logic        fl;
        logic        h;
        logic        mb;
        logic [15:0] sc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [3:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       u1 = 0, u2 = 0, mr = 0, mds = 0, hlt = 0, res = 0, br = 0;
    logic [1:0] pcw, ifw, bub, fl, hl, mb;
    logic [15:0] sca;
    logic [3:0]  scb;

    int total = 0;
    int bad = 0;
    exp_t q[2][$];

    // model state: cycles still owed per hazard, plus running stall count
    int ll[2], md[2], sc[2];
    bit hm[2];
    int LL[2]   = '{2, 1};
    int ML[2]   = '{4, 3};
    int RZ[2]   = '{1, 0};
    int SMAX[2] = '{65535, 15};

    hazard_stall_ctrl #(.REG_AW(4), .LOAD_LAT(2), .MD_LAT(4), .R0_ZERO(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .ex_rd(rd), .ex_mem_read(mr), .id_md_start(mds), .id_halt(hlt), .resume(res),
        .ex_branch_taken(br), .pc_write(pcw[0]), .ifid_write(ifw[0]), .idex_bubble(bub[0]),
        .ifid_flush(fl[0]), .halted(hl[0]), .md_busy(mb[0]), .stall_cycles(sca));

    hazard_stall_ctrl #(.REG_AW(4), .LOAD_LAT(1), .MD_LAT(3), .R0_ZERO(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(rs1), .id_rs2(rs2), .id_rs1_used(u1), .id_rs2_used(u2),
        .ex_rd(rd), .ex_mem_read(mr), .id_md_start(mds), .id_halt(hlt), .resume(res),
        .ex_branch_taken(br), .pc_write(pcw[1]), .ifid_write(ifw[1]), .idex_bubble(bub[1]),
        .ifid_flush(fl[1]), .halted(hl[1]), .md_busy(mb[1]), .stall_cycles(scb));

    task automatic predict();
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit hit, st;
            e = '{pc: 1'b1, ifid: 1'b1, bub: 1'b0, fl: 1'b0, h: 1'b0, mb: 1'b0, sc: 16'd0};
            st = 0;
            hit = mr && ((u1 && rs1 == rd) || (u2 && rs2 == rd)) && !(RZ[d] != 0 && rd == 0);
            if (!rst_n) begin
                ll[d] = 0; md[d] = 0; hm[d] = 0; sc[d] = 0;
            end else if (hm[d]) begin
                st = 1; e.h = 1'b1; hm[d] = !res;
            end else if (md[d] > 0) begin
                st = 1; e.mb = 1'b1; e.fl = br; md[d]--;
            end else if (br) begin
                e.fl = 1'b1; e.bub = 1'b1; ll[d] = 0;
            end else if (ll[d] > 0) begin
                st = 1; ll[d]--;
            end else if (hit) begin
                st = 1; ll[d] = LL[d] - 1;
            end else if (mds) begin
                md[d] = ML[d];
            end else if (hlt) begin
                st = 1; hm[d] = 1;
            end
            e.pc = !st;
            e.ifid = !st;
            e.bub = e.bub | st;
            e.sc = 16'(sc[d]);
            q[d].push_back(e);
            if (st && sc[d] < SMAX[d]) sc[d]++;
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] a1, a2, dd,
                       input logic x1, x2, m, s, h, rs, b);
        @(posedge clk);
        #1;
        rst_n = r; rs1 = a1; rs2 = a2; rd = dd; u1 = x1; u2 = x2;
        mr = m; mds = s; hlt = h; res = rs; br = b;
        predict();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (q[d].size() > 0) begin
                exp_t e, g;
                e = q[d].pop_front();
                g = {pcw[d], ifw[d], bub[d], fl[d], hl[d], mb[d], (d == 0) ? sca : {12'd0, scb}};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL dut%0d outputs t=%0t got pc=%b ifid=%b bub=%b fl=%b h=%b mb=%b sc=%0d want pc=%b ifid=%b bub=%b fl=%b h=%b mb=%b sc=%0d",
                             d, $time, g.pc, g.ifid, g.bub, g.fl, g.h, g.mb, g.sc,
                             e.pc, e.ifid, e.bub, e.fl, e.h, e.mb, e.sc);
                end
            end
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 3, 3, 0, 1, 1, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(6);
        cyc(1, 3, 0, 3, 1, 0, 1, 0, 1, 0, 1);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(9);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(22);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 99) != 0,
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        repeat (2) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (q[d].size() != 0) begin
                bad++;
                $display("FAIL dut%0d drain got %0d pending want 0", d, q[d].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
